// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - instruction FIFO, registered ALU issue and result capture stage
module alu_issue_stage #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic [OP_W-1:0]            in_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_op,
    input  logic [DATA_W-1:0]          alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [OP_W-1:0]            out_op,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OP_W + 2 * DATA_W;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              issue_valid_q, issue_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic              out_zero_q, out_zero_d;

    logic push;
    logic pop;
    logic adv;

    // in_ready depends on registered count only, so a full FIFO refuses a push
    // even when the same edge pops an entry.
    always_comb begin
        push = in_valid && (count_q < CNT_W'(DEPTH));
        adv  = issue_valid_q && (!out_valid_q || out_ready);
        pop  = (count_q != '0) && (!issue_valid_q || adv);
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_op, in_a, in_b};
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A drained issue register parks at op 0 with zero operands.
    always_comb begin
        issue_valid_d = issue_valid_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        if (pop) begin
            {alu_op_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
            issue_valid_d = 1'b1;
        end else if (adv) begin
            issue_valid_d = 1'b0;
            alu_a_d       = '0;
            alu_b_d       = '0;
            alu_op_d      = '0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_zero_d   = out_zero_q;
        if (adv) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_op_d     = alu_op_q;
            out_zero_d   = (alu_result == '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_op_q      <= '0;
            out_zero_q    <= 1'b1;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_op_q      <= out_op_d;
            out_zero_q    <= out_zero_d;
        end
    end

    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign count      = count_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;
    assign out_zero   = out_zero_q;

endmodule
